// File: rtl/avalon_waitstate_ram.sv
// Avalon-MM responder memory with fixed or LFSR-driven wait states, a side-band
// preload port and sticky protocol/range error flags.
module avalon_waitstate_ram #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [1:0]  err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t state, state_nx;

    logic [31:0]          mem [DEPTH];
    logic [7:0]           lfsr;
    logic [3:0]           cnt;
    logic                 lat_write;
    logic                 lat_oob;
    logic [ADDR_BITS-1:0] lat_idx;
    logic [31:0]          lat_wdata;
    logic [3:0]           lat_be;

    logic [31:0] bus_off;
    logic [31:0] load_off;
    logic        bus_oob;
    logic        load_oob;
    logic        req_valid;
    logic        req_none;
    logic [3:0]  wait_load;

    // Word offsets are kept full width so anything below BASE_ADDR wraps out of range.
    assign bus_off   = (address - BASE_ADDR) >> 2;
    assign load_off  = (load_addr - BASE_ADDR) >> 2;
    assign bus_oob   = bus_off >= 32'(DEPTH);
    assign load_oob  = load_off >= 32'(DEPTH);
    assign req_valid = (read ^ write) & ~load_en;
    assign req_none  = ~read & ~write;
    assign wait_load = RANDOM_WAIT ? {2'b00, lfsr[1:0]} : 4'(WAIT_CYCLES);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: each combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = (wait_load == 4'd0) ? DONE : COUNT;
            COUNT:   if (req_none) state_nx = IDLE;
                     else if (cnt == 4'd1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        waitrequest = 1'b0;
        case (state)
            IDLE:    waitrequest = load_en ? (read | write) : (read ^ write);
            COUNT:   waitrequest = 1'b1;
            default: waitrequest = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= LFSR_SEED;
            cnt       <= '0;
            readdata  <= '0;
            err       <= '0;
            lat_write <= 1'b0;
            lat_oob   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (load_en && load_oob) err[1] <= 1'b1;
            case (state)
                IDLE: begin
                    if (read && write) err[0] <= 1'b1;
                    if (req_valid) begin
                        lat_write <= write;
                        lat_oob   <= bus_oob;
                        lat_idx   <= bus_off[ADDR_BITS-1:0];
                        lat_wdata <= writedata;
                        lat_be    <= byteenable;
                        cnt       <= wait_load;
                        if (bus_oob) err[1] <= 1'b1;
                        // Zero-wait read: DONE is next, so register the word now.
                        if (read && wait_load == 4'd0)
                            readdata <= bus_oob ? '0 : mem[bus_off[ADDR_BITS-1:0]];
                    end
                end
                COUNT: begin
                    if (req_none) begin
                        err[0] <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1 && !lat_write)
                            readdata <= lat_oob ? '0 : mem[lat_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: memory contents are deliberately not reset; reset only gates the
    // write enables so a transfer interrupted by reset never commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == DONE && lat_write && !lat_oob) begin
                for (int i = 0; i < 4; i++)
                    if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
            // The preload port wins over a bus write to the same word.
            if (load_en && !load_oob) mem[load_off[ADDR_BITS-1:0]] <= load_data;
        end
    end

endmodule
